// File: rtl/ex_unit.sv
// Registered execute stage: one ALU op per valid/ready handshake, shifts done
// iteratively (SHIFT_STEP bits/cycle) unless EX_UNIT_BARREL_EN selects a barrel shifter.
module ex_unit #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  parameter int REG_AW     = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        alu_op_i,
  input  logic              alu_alt_op_i,
  input  logic [XLEN-1:0]   operand1_i,
  input  logic [XLEN-1:0]   operand2_i,
  input  logic [REG_AW-1:0] rd_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   result_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              busy_o
);

  localparam int SAW = $clog2(XLEN);
  localparam logic [SAW:0] STEP_W = (SAW+1)'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]     shVal_q, shVal_d;
  logic [SAW-1:0]      shAmt_q, shAmt_d;
  logic                shLeft_q, shLeft_d;
  logic                shArith_q, shArith_d;
  logic [REG_AW-1:0]   shRd_q, shRd_d;

  logic [SAW-1:0]      amt;
  logic                isShift;
  logic                goIter;
  logic                accept;
  logic [XLEN-1:0]     aluRes;
  logic [SAW:0]        step;
  logic [XLEN-1:0]     shifted;
  logic [SAW-1:0]      remaining;

  assign amt     = operand2_i[SAW-1:0];
  assign isShift = (alu_op_i == 3'b001) || (alu_op_i == 3'b101);
  assign ready_o = (state_q == IDLE) || ((state_q == DONE) && ready_i);
  assign accept  = valid_i && ready_o && !flush_i;
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;
  assign rd_o     = rd_q;

`ifdef EX_UNIT_BARREL_EN
  assign goIter = 1'b0;
  assign busy_o = 1'b0;
`else
  assign goIter = isShift && (amt != '0);
  assign busy_o = (state_q == SHIFT);
`endif

  // Single-cycle results; in iterative mode a shift only lands here with amount 0.
  always_comb begin
    aluRes = '0;
    case (alu_op_i)
      3'b000: aluRes = alu_alt_op_i ? operand1_i - operand2_i : operand1_i + operand2_i;
`ifdef EX_UNIT_BARREL_EN
      3'b001: aluRes = operand1_i << amt;
      3'b101: begin
        if (alu_alt_op_i) aluRes = $signed(operand1_i) >>> amt;
        else              aluRes = operand1_i >> amt;
      end
`else
      3'b001: aluRes = operand1_i;
      3'b101: aluRes = operand1_i;
`endif
      3'b010: aluRes = {{(XLEN-1){1'b0}}, ($signed(operand1_i) < $signed(operand2_i))};
      3'b011: aluRes = {{(XLEN-1){1'b0}}, (operand1_i < operand2_i)};
      3'b100: aluRes = operand1_i ^ operand2_i;
      3'b110: aluRes = operand1_i | operand2_i;
      3'b111: aluRes = operand1_i & operand2_i;
      default: aluRes = '0;
    endcase
  end

  always_comb begin
    step = ({1'b0, shAmt_q} >= STEP_W) ? STEP_W : {1'b0, shAmt_q};
    if (shLeft_q)       shifted = shVal_q << step;
    else if (shArith_q) shifted = $signed(shVal_q) >>> step;
    else                shifted = shVal_q >> step;
    remaining = shAmt_q - step[SAW-1:0];
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    rd_d      = rd_q;
    shVal_d   = shVal_q;
    shAmt_d   = shAmt_q;
    shLeft_d  = shLeft_q;
    shArith_d = shArith_q;
    shRd_d    = shRd_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        SHIFT: begin
          shVal_d = shifted;
          shAmt_d = remaining;
          if (remaining == '0) begin
            state_d  = DONE;
            result_d = shifted;
            rd_d     = shRd_q;
          end
        end
        DONE:    if (ready_i) state_d = IDLE;
        default: ;
      endcase
      // Accept overrides the DONE->IDLE drain so back-to-back ops see no bubble.
      if (accept) begin
        if (goIter) begin
          state_d   = SHIFT;
          shVal_d   = operand1_i;
          shAmt_d   = amt;
          shLeft_d  = (alu_op_i == 3'b001);
          shArith_d = alu_alt_op_i;
          shRd_d    = rd_i;
        end else begin
          state_d  = DONE;
          result_d = aluRes;
          rd_d     = rd_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      result_q  <= '0;
      rd_q      <= '0;
      shVal_q   <= '0;
      shAmt_q   <= '0;
      shLeft_q  <= 1'b0;
      shArith_q <= 1'b0;
      shRd_q    <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      shVal_q   <= shVal_d;
      shAmt_q   <= shAmt_d;
      shLeft_q  <= shLeft_d;
      shArith_q <= shArith_d;
      shRd_q    <= shRd_d;
    end
  end

endmodule

// File: tb/tb_ex_unit.sv
// Self-checking bench for ex_unit: vector table for the ALU ops plus directed
// sequences for busy/backpressure/flush/async reset.
module tb_ex_unit;

  localparam int XLEN = 32;
  localparam int STEP = 1;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            validIn = 1'b0;
  logic            readyOut;
  logic [2:0]      op = '0;
  logic            alt = 1'b0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic [AW-1:0]   rd = '0;
  logic            validOut;
  logic            readyIn = 1'b1;
  logic [XLEN-1:0] result;
  logic [AW-1:0]   rdOut;
  logic            busy;

  int errors = 0;
  int checks = 0;

  ex_unit #(.XLEN(XLEN), .SHIFT_STEP(STEP), .REG_AW(AW)) dut (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .valid_i(validIn), .ready_o(readyOut),
    .alu_op_i(op), .alu_alt_op_i(alt), .operand1_i(a), .operand2_i(b), .rd_i(rd),
    .valid_o(validOut), .ready_i(readyIn), .result_o(result), .rd_o(rdOut), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        alt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  rd;
    string       name;
  } vec_t;

  vec_t vecs[18];

  function automatic int expLat(input logic [2:0] o, input logic [31:0] bb);
    int amt;
    amt = int'(bb[4:0]);
`ifdef EX_UNIT_BARREL_EN
    return 1;
`else
    if ((o == 3'b001 || o == 3'b101) && amt != 0) return 1 + (amt + STEP - 1) / STEP;
    return 1;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one op, lets it be accepted at the next edge, then drops valid_i.
  task automatic applyStimulus(input logic [2:0] o, input logic al, input logic [31:0] x,
                               input logic [31:0] y, input logic [4:0] r);
    op = o; alt = al; a = x; b = y; rd = r; validIn = 1'b1;
    tick();
    validIn = 1'b0;
  endtask

  task automatic waitValid(output int lat);
    lat = 1;
    while (!validOut && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  int lat;
  int exl;
  logic seenValid;
  logic [31:0] lastRes;

  initial begin
    vecs[0]  = '{3'b000, 1'b0, 32'd5,         32'd7,         32'd12,        5'd3,  "add"};
    vecs[1]  = '{3'b000, 1'b1, 32'd0,         32'd1,         32'hFFFFFFFF,  5'd4,  "subWrap"};
    vecs[2]  = '{3'b010, 1'b0, 32'hFFFFFFFF,  32'd1,         32'd1,         5'd5,  "sltNeg"};
    vecs[3]  = '{3'b011, 1'b0, 32'hFFFFFFFF,  32'd1,         32'd0,         5'd6,  "sltuBig"};
    vecs[4]  = '{3'b100, 1'b0, 32'hF0F0F0F0,  32'h0FF00FF0,  32'hFF00FF00,  5'd7,  "xor"};
    vecs[5]  = '{3'b110, 1'b0, 32'h12340000,  32'h00005678,  32'h12345678,  5'd8,  "or"};
    vecs[6]  = '{3'b111, 1'b0, 32'hFFFF0000,  32'h12345678,  32'h12340000,  5'd9,  "and"};
    vecs[7]  = '{3'b000, 1'b0, 32'hFFFFFFFF,  32'd2,         32'd1,         5'd10, "addWrap"};
    vecs[8]  = '{3'b010, 1'b0, 32'd1,         32'hFFFFFFFF,  32'd0,         5'd11, "sltPos"};
    vecs[9]  = '{3'b011, 1'b0, 32'd1,         32'hFFFFFFFF,  32'd1,         5'd12, "sltuSmall"};
    vecs[10] = '{3'b001, 1'b0, 32'd1,         32'd3,         32'd8,         5'd13, "sll3"};
    vecs[11] = '{3'b101, 1'b0, 32'h80000000,  32'd4,         32'h08000000,  5'd14, "srl4"};
    vecs[12] = '{3'b101, 1'b1, 32'h80000000,  32'd4,         32'hF8000000,  5'd15, "sra4"};
    vecs[13] = '{3'b101, 1'b1, 32'h80000000,  32'd32,        32'h80000000,  5'd16, "sraAmt0"};
    vecs[14] = '{3'b001, 1'b0, 32'h0000000F,  32'h23,        32'h00000078,  5'd17, "sllUpperIgn"};
    vecs[15] = '{3'b100, 1'b1, 32'd3,         32'd5,         32'd6,         5'd18, "xorAltIgn"};
    vecs[16] = '{3'b101, 1'b1, 32'h7FFFFFFF,  32'd31,        32'd0,         5'd19, "sraPos31"};
    vecs[17] = '{3'b101, 1'b0, 32'hFFFFFFFF,  32'd31,        32'd1,         5'd20, "srl31"};

    #12;
    checkOutput("rstValid",  {31'd0, validOut}, 32'd0);
    checkOutput("rstResult", result, 32'd0);
    checkOutput("rstRd",     {27'd0, rdOut}, 32'd0);
    checkOutput("rstBusy",   {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("idleReady", {31'd0, readyOut}, 32'd1);
    checkOutput("idleValid", {31'd0, validOut}, 32'd0);

    readyIn = 1'b1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].alt, vecs[i].a, vecs[i].b, vecs[i].rd);
      waitValid(lat);
      exl = expLat(vecs[i].op, vecs[i].b);
      checkOutput({vecs[i].name, "_valid"}, {31'd0, validOut}, 32'd1);
      checkOutput({vecs[i].name, "_lat"}, lat, exl);
      checkOutput({vecs[i].name, "_res"}, result, vecs[i].res);
      checkOutput({vecs[i].name, "_rd"}, {27'd0, rdOut}, {27'd0, vecs[i].rd});
      tick();
      checkOutput({vecs[i].name, "_drop"}, {31'd0, validOut}, 32'd0);
    end

    // Iterative SRA: busy and not ready while shifting.
    applyStimulus(3'b101, 1'b1, 32'h80000000, 32'd4, 5'd21);
    exl = expLat(3'b101, 32'd4);
    for (int i = 0; i < exl - 1; i++) begin
      checkOutput("sraBusy",  {31'd0, busy}, 32'd1);
      checkOutput("sraReady", {31'd0, readyOut}, 32'd0);
      tick();
    end
    checkOutput("sraDoneValid", {31'd0, validOut}, 32'd1);
    checkOutput("sraDoneRes",   result, 32'hF8000000);
    checkOutput("sraDoneBusy",  {31'd0, busy}, 32'd0);
    tick();

    // Backpressure, then back-to-back accept from DONE.
    readyIn = 1'b0;
    applyStimulus(3'b000, 1'b0, 32'd100, 32'd23, 5'd7);
    checkOutput("bpValid0", {31'd0, validOut}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bpValid", {31'd0, validOut}, 32'd1);
      checkOutput("bpRes",   result, 32'd123);
      checkOutput("bpRd",    {27'd0, rdOut}, 32'd7);
      checkOutput("bpReady", {31'd0, readyOut}, 32'd0);
    end
    readyIn = 1'b1;
    op = 3'b100; alt = 1'b0; a = 32'hF; b = 32'h3; rd = 5'd9; validIn = 1'b1;
    #1;
    checkOutput("b2bReady", {31'd0, readyOut}, 32'd1);
    tick();
    validIn = 1'b0;
    checkOutput("b2bValid", {31'd0, validOut}, 32'd1);
    checkOutput("b2bRes",   result, 32'hC);
    checkOutput("b2bRd",    {27'd0, rdOut}, 32'd9);
    lastRes = 32'hC;
    tick();
    checkOutput("b2bDrop", {31'd0, validOut}, 32'd0);

    // Flush mid-shift.
    readyIn = 1'b0;
    applyStimulus(3'b001, 1'b0, 32'd1, 32'd31, 5'd4);
`ifdef EX_UNIT_BARREL_EN
    lastRes = 32'h80000000;
`endif
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    readyIn = 1'b1;
    checkOutput("flushValid", {31'd0, validOut}, 32'd0);
    checkOutput("flushBusy",  {31'd0, busy}, 32'd0);
    checkOutput("flushReady", {31'd0, readyOut}, 32'd1);
    seenValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (validOut) seenValid = 1'b1;
      tick();
    end
    checkOutput("flushNoValid", {31'd0, seenValid}, 32'd0);
    checkOutput("flushKeepRes", result, lastRes);

    // Flush together with valid_i drops the op.
    op = 3'b000; alt = 1'b0; a = 32'd1; b = 32'd1; rd = 5'd2;
    validIn = 1'b1; flush = 1'b1;
    tick();
    validIn = 1'b0; flush = 1'b0;
    checkOutput("flushDropValid", {31'd0, validOut}, 32'd0);
    checkOutput("flushDropRes",   result, lastRes);
    tick();
    checkOutput("flushDropValid2", {31'd0, validOut}, 32'd0);

    // Async reset while holding a result under backpressure.
    readyIn = 1'b0;
    applyStimulus(3'b000, 1'b0, 32'd40, 32'd2, 5'd12);
    checkOutput("arHeldValid", {31'd0, validOut}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arValid",  {31'd0, validOut}, 32'd0);
    checkOutput("arResult", result, 32'd0);
    checkOutput("arRd",     {27'd0, rdOut}, 32'd0);
    #1;
    rst_n = 1'b1;
    readyIn = 1'b1;
    tick();
    checkOutput("arReady", {31'd0, readyOut}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_unit.md
Name: ex_unit

Overview:
- Parametrised, registered execute stage that replaces the purely combinational execute path of the single-cycle core.
- Accepts one decoded ALU operation per handshake. Runs non-shift ops in one cycle and shifts iteratively, SHIFT_STEP bits per cycle.
- Presents a registered result with destination register tag to writeback over a valid/ready interface.
- Supports pipeline flush; first building block of the pipelined core.

Parameters:
- XLEN, 32, datapath width; power of 2, >= 8.
- SHIFT_STEP, 1, max bits shifted per iteration; power of 2, 1..XLEN.
- REG_AW, 5, width of destination register tag.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset, asynchronous, active-low; (0 = reset).
- flush_i  input  1  synchronous kill of in-flight and output-held operation.
- valid_i  input  1  upstream operation valid.
- ready_o  output  1  unit can accept an operation this cycle.
- alu_op_i  input  3  RV32I funct3 encoding.
- alu_alt_op_i  input  1  SUB for 000, SRA for 101; ignored otherwise.
- operand1_i  input  XLEN  rs1 value.
- operand2_i  input  XLEN  rs2 value or immediate.
- rd_i  input  REG_AW  destination register tag.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.
- result_o  output  XLEN  registered result.
- rd_o  output  REG_AW  tag of result.
- busy_o  output  1  high while in SHIFT state.

Behaviour:
- Reset (rst_i low, asynchronous): state=IDLE; valid_o=0, result_o=0, rd_o=0, busy_o=0, internal shift count 0. ready_o=1 after reset.
- Ops: 000 add / sub(alt); 001 SLL; 010 SLT signed (result 1 or 0); 011 SLTU; 100 XOR; 101 SRL / SRA(alt); 110 OR; 111 AND. Add/sub wrap modulo 2^XLEN.
- Shift amount = operand2_i[log2(XLEN)-1:0]; upper bits ignored.
- Accept = valid_i & ready_o & !flush_i.
- ready_o = (state==IDLE) | (state==DONE & ready_i). Combinational; no dependence on valid_i.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, accept non-shift or shift with amount 0 -> DONE. result_o/rd_o loaded at that edge, valid_o=1. Latency 1.
  - IDLE, accept shift with amount>0 -> SHIFT. Latch operand, amount, op, rd.
  - SHIFT: each cycle shift by min(remaining, SHIFT_STEP); SRA fills with the sign bit. When remaining reaches 0 -> DONE with valid_o=1.
  - Total shift latency = 1 + ceil(amount/SHIFT_STEP) cycles from accept to valid_o.
  - DONE, ready_i=1, accept -> load new op (back-to-back, no bubble). Next state DONE or SHIFT as from IDLE.
  - DONE, ready_i=1, no accept -> IDLE, valid_o=0.
  - DONE, ready_i=0: result_o, rd_o, valid_o held stable.
- busy_o=1 iff state==SHIFT. ready_o=0 in SHIFT.
- flush_i=1 (any state) -> IDLE next edge, valid_o=0. Concurrent valid_i is not accepted. Flush has priority over ready_i completion. result_o retains last value.
- Reset mid-shift aborts immediately; no partial result is ever presented.

Optional Feature:
- Macro EX_UNIT_BARREL_EN.
- Defined: shifts use a full barrel shifter. All ops have latency 1; SHIFT state unreachable; busy_o constant 0; SHIFT_STEP ignored.
- Undefined: iterative shifting as above.

Test Plan:
- Reset then ADD: op=000, alt=0, 5+7, rd=3, ready_i=1 -> next cycle valid_o=1, result_o=12, rd_o=3. Following cycle valid_o=0.
- SUB wrap and SLT: 0-1 -> 0xFFFFFFFF. SLT(0xFFFFFFFF,1) -> 1. SLTU(0xFFFFFFFF,1) -> 0.
- SRA, SHIFT_STEP=1: 0x80000000 >>> 4 -> busy_o high 4 cycles, ready_o low. valid_o at cycle 5, result 0xF8000000. Shift amount 0 -> latency 1, operand unchanged.
- Backpressure: ready_i=0 for 3 cycles after valid_o -> result_o/rd_o stable, ready_o=0. ready_i=1 with new op valid same cycle -> new result next cycle, no bubble.
- Flush mid-shift: SLL 1<<31, flush_i at cycle 3 -> valid_o never asserts, IDLE, ready_o=1 next cycle. Flush with valid_i=1 -> op dropped.
- Async reset while valid_o=1 and ready_i=0 -> valid_o=0 immediately, no clock edge needed. Repeat SLL with EX_UNIT_BARREL_EN -> latency 1.
